// File: rtl/shift_deserializer.sv
// Serial-to-parallel deserializer with sync framing.
// Flags aborted frames and words dropped while the output is held.
module shift_deserializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             bit_en,
  input  logic             s_in,
  input  logic             sync,
  input  logic             d_ack,
  output logic [WIDTH-1:0] d_out,
  output logic             d_valid,
  output logic             frame_err,
  output logic             overrun
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [WIDTH-1:0] shifted, first;
  logic             done, abort, load;

  // First bit is placed so that WIDTH-1 further shifts land it at the far end.
  always_comb begin
    if (MSB_FIRST) begin
      shifted = (sreg_q << 1) | WIDTH'(s_in);
      first   = WIDTH'(s_in);
    end else begin
      shifted = (sreg_q >> 1) | {s_in, {(WIDTH-1){1'b0}}};
      first   = {s_in, {(WIDTH-1){1'b0}}};
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    sreg_d  = sreg_q;
    done    = 1'b0;
    abort   = 1'b0;
    if (bit_en) begin
      case (state_q)
        IDLE: begin
          if (sync) begin
            sreg_d  = first;
            count_d = CW'(1);
            state_d = SHIFT;
          end
        end
        SHIFT: begin
          if (sync) begin
            abort   = 1'b1;
            sreg_d  = first;
            count_d = CW'(1);
          end else if (count_q == CW'(WIDTH - 1)) begin
            done    = 1'b1;
            sreg_d  = shifted;
            count_d = count_q + CW'(1);
            state_d = IDLE;
          end else begin
            sreg_d  = shifted;
            count_d = count_q + CW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign load = done && (!d_valid || d_ack);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      count_q <= '0;
      sreg_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      sreg_q  <= sreg_d;
    end
  end

  // A completing word wins over a same-edge ack, so d_valid stays set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      d_out     <= '0;
      d_valid   <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= abort;
      if (load) begin
        d_out   <= shifted;
        d_valid <= 1'b1;
      end else if (d_ack) begin
        d_valid <= 1'b0;
      end
      if (done && !load) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_shift_deserializer.sv
// Directed bench for shift_deserializer.
// Runs MSB-first and LSB-first instances side by side on one stream.
module tb_shift_deserializer;

  logic       clk;
  logic       reset_n;
  logic       bit_en, s_in, sync, d_ack;
  logic [7:0] m_out, l_out;
  logic       m_valid, m_ferr, m_ovr;
  logic       l_valid, l_ferr, l_ovr;

  int n_cmp = 0;
  int n_err = 0;

  shift_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .reset_n(reset_n), .bit_en(bit_en), .s_in(s_in),
    .sync(sync), .d_ack(d_ack), .d_out(m_out), .d_valid(m_valid),
    .frame_err(m_ferr), .overrun(m_ovr)
  );

  shift_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset_n(reset_n), .bit_en(bit_en), .s_in(s_in),
    .sync(sync), .d_ack(d_ack), .d_out(l_out), .d_valid(l_valid),
    .frame_err(l_ferr), .overrun(l_ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] rev8(input logic [7:0] w);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = w[7-i];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: drive at negedge, return at the next negedge.
  task automatic tick(input logic en, input logic b, input logic s,
                      input logic a);
    bit_en = en;
    s_in   = b;
    sync   = s;
    d_ack  = a;
    @(negedge clk);
  endtask

  // Bits lo..hi of w (MSB first on the wire), gap idle cycles after each.
  task automatic send_bits(input logic [7:0] w, input int lo, input int hi,
                           input int gap, input logic ack_last);
    for (int i = lo; i <= hi; i++) begin
      tick(1'b1, w[7-i], i == 0, ack_last && i == 7);
      for (int g = 0; g < gap; g++) tick(1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic expect_out(input string tag, input logic [7:0] w,
                            input logic v, input logic o, input logic fe);
    chk({tag, ".m_out"}, 32'(m_out), 32'(w));
    chk({tag, ".l_out"}, 32'(l_out), 32'(rev8(w)));
    chk({tag, ".m_valid"}, 32'(m_valid), 32'(v));
    chk({tag, ".l_valid"}, 32'(l_valid), 32'(v));
    chk({tag, ".m_ovr"}, 32'(m_ovr), 32'(o));
    chk({tag, ".l_ovr"}, 32'(l_ovr), 32'(o));
    chk({tag, ".m_ferr"}, 32'(m_ferr), 32'(fe));
    chk({tag, ".l_ferr"}, 32'(l_ferr), 32'(fe));
  endtask

  task automatic do_reset(input string tag);
    bit_en  = 1'b0;
    sync    = 1'b0;
    s_in    = 1'b0;
    d_ack   = 1'b0;
    reset_n = 1'b0;
    #1;
    expect_out(tag, 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    bit_en  = 1'b0;
    s_in    = 1'b0;
    sync    = 1'b0;
    d_ack   = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    do_reset("reset");

    // Non-sync strobe in IDLE is ignored
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    expect_out("idle_nosync", 8'h00, 1'b0, 1'b0, 1'b0);

    send_bits(8'hA5, 0, 7, 0, 1'b0);
    expect_out("a5", 8'hA5, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    expect_out("a5_ack", 8'hA5, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    expect_out("ack_idle", 8'hA5, 1'b0, 1'b0, 1'b0);

    send_bits(8'h01, 0, 7, 0, 1'b0);
    expect_out("w01", 8'h01, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b1);

    // Overrun: second word dropped while first still held
    send_bits(8'h11, 0, 7, 0, 1'b0);
    expect_out("w11", 8'h11, 1'b1, 1'b0, 1'b0);
    send_bits(8'h22, 0, 7, 0, 1'b0);
    expect_out("w22_drop", 8'h11, 1'b1, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    expect_out("ovr_sticky", 8'h11, 1'b0, 1'b1, 1'b0);
    do_reset("reset2");

    // Ack on the last-bit edge lets the new word load
    send_bits(8'h11, 0, 7, 0, 1'b0);
    send_bits(8'h22, 0, 7, 0, 1'b1);
    expect_out("w22_ack", 8'h22, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b1);

    // Partial frame aborted by sync
    send_bits(8'hFF, 0, 4, 0, 1'b0);
    send_bits(8'hC3, 0, 0, 0, 1'b0);
    expect_out("abort5", 8'h22, 1'b0, 1'b0, 1'b1);
    send_bits(8'hC3, 1, 1, 0, 1'b0);
    expect_out("abort5_end", 8'h22, 1'b0, 1'b0, 1'b0);
    send_bits(8'hC3, 2, 7, 0, 1'b0);
    expect_out("c3", 8'hC3, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b1);

    // Sync on what would be the final bit takes priority
    send_bits(8'hFF, 0, 6, 0, 1'b0);
    send_bits(8'h96, 0, 0, 0, 1'b0);
    expect_out("abort7", 8'hC3, 1'b0, 1'b0, 1'b1);
    send_bits(8'h96, 1, 7, 0, 1'b0);
    expect_out("w96", 8'h96, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b1);

    // Strobe every third cycle
    send_bits(8'h5A, 0, 3, 2, 1'b0);
    expect_out("gap_mid", 8'h96, 1'b0, 1'b0, 1'b0);
    send_bits(8'h5A, 4, 7, 2, 1'b0);
    expect_out("gap_5a", 8'h5A, 1'b1, 1'b0, 1'b0);

    // Reset mid-frame, then a stray non-sync bit, then a clean frame
    send_bits(8'hFF, 0, 3, 0, 1'b0);
    do_reset("reset_mid");
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    expect_out("post_rst", 8'h00, 1'b0, 1'b0, 1'b0);
    send_bits(8'h0F, 0, 7, 0, 1'b0);
    expect_out("w0f", 8'h0F, 1'b1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
